// File: rtl/sc_datapath2_if.sv
// Controller <-> sc_datapath2 bundle: control word, memory read data and datapath status/addresses.
interface sc_datapath2_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 16,
  parameter int RW    = $clog2(NREG)
);
  logic [WIDTH-1:0] imm;
  logic [RW-1:0]    opAIdx;
  logic [RW-1:0]    opBIdx;
  logic             immSel;
  logic [RW-1:0]    wbIdx;
  logic             wbEn;
  logic [1:0]       resSel;
  logic [2:0]       aluCtl;
  logic [2:0]       shiftCtl;
  logic             srWbEn;
  logic             cmpFlag;
  logic             mulStart;
  logic             iAregCtl;
  logic             dAregCtl;
  logic             dOutCtl;
  logic [WIDTH-1:0] dIn;
  logic             mulBusy;
  logic             mulDone;
  logic             zFlag;
  logic             nFlag;
  logic             cFlag;
  logic             vFlag;
  logic [WIDTH-1:0] iAddr;
  logic [WIDTH-1:0] dAddr;
  logic [WIDTH-1:0] dOut;

  modport master (
    output imm, opAIdx, opBIdx, immSel, wbIdx, wbEn, resSel, aluCtl, shiftCtl,
           srWbEn, cmpFlag, mulStart, iAregCtl, dAregCtl, dOutCtl, dIn,
    input  mulBusy, mulDone, zFlag, nFlag, cFlag, vFlag, iAddr, dAddr, dOut
  );

  modport slave (
    input  imm, opAIdx, opBIdx, immSel, wbIdx, wbEn, resSel, aluCtl, shiftCtl,
           srWbEn, cmpFlag, mulStart, iAregCtl, dAregCtl, dOutCtl, dIn,
    output mulBusy, mulDone, zFlag, nFlag, cFlag, vFlag, iAddr, dAddr, dOut
  );
endinterface

// File: rtl/sc_datapath2.sv
// SimpleCore datapath: regfile, ALU, shifter, NZCV, address/data registers; outputs registered, iAddr stalls
// while a multiply runs. Iterative WIDTH-cycle multiplier present only when SC_DP_MUL_EN is defined.
module sc_datapath2 #(
  parameter int WIDTH = 16,
  parameter int NREG  = 16,
  parameter int RW    = $clog2(NREG)
) (
  input logic           clk,
  input logic           reset,
  sc_datapath2_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [RW-1:0] PC_IDX = RW'(NREG - 1);

  logic [WIDTH-1:0] regFile [NREG];
  logic [WIDTH-1:0] iAddrR, dAddrR, dOutR;
  logic             nR, zR, cR, vR;
  logic [WIDTH-1:0] busA, busB, regB, aluOut, shOut, mulRes, busW;
  logic [WIDTH:0]   sum, diff;
  logic             aluN, aluZ, aluC, aluV;
  logic             mulBusyW, mulDoneW;
  logic [SW-1:0]    shAmt;
  logic [SW:0]      shInv;

  // The top register index aliases the instruction address; its storage slot is never written.
  assign busA = (bus.opAIdx == PC_IDX) ? iAddrR : regFile[bus.opAIdx];
  assign regB = (bus.opBIdx == PC_IDX) ? iAddrR : regFile[bus.opBIdx];
  assign busB = bus.immSel ? bus.imm : regB;

  assign sum  = {1'b0, busA} + {1'b0, busB};
  assign diff = {1'b0, busA} - {1'b0, busB};

  always_comb begin
    aluOut = busA;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (bus.aluCtl)
      3'b000: begin
        aluOut = sum[WIDTH-1:0];
        aluC   = sum[WIDTH];
        aluV   = (busA[WIDTH-1] == busB[WIDTH-1]) && (sum[WIDTH-1] != busA[WIDTH-1]);
      end
      3'b001: begin
        aluOut = diff[WIDTH-1:0];
        aluC   = diff[WIDTH];
        aluV   = (busA[WIDTH-1] != busB[WIDTH-1]) && (diff[WIDTH-1] != busA[WIDTH-1]);
      end
      3'b010:  aluOut = busA & busB;
      3'b011:  aluOut = busA | busB;
      3'b100:  aluOut = busA ^ busB;
      3'b101:  aluOut = ~busA;
      3'b110:  aluOut = busB;
      default: aluOut = busA;
    endcase
  end

  assign aluZ = (aluOut == '0);
  assign aluN = aluOut[WIDTH-1];

  // Rotates use the complementary shift; amount 0 gives shInv=WIDTH, which shifts everything out.
  assign shAmt = busB[SW-1:0];
  assign shInv = (SW + 1)'(WIDTH) - {1'b0, shAmt};

  always_comb begin
    shOut = busA;
    case (bus.shiftCtl)
      3'b000:  shOut = busA << shAmt;
      3'b001:  shOut = busA >> shAmt;
      3'b010:  shOut = $signed(busA) >>> shAmt;
      3'b011:  shOut = (busA << shAmt) | (busA >> shInv);
      3'b100:  shOut = (busA >> shAmt) | (busA << shInv);
      default: shOut = busA;
    endcase
  end

  always_comb begin
    case (bus.resSel)
      2'b00:   busW = aluOut;
      2'b01:   busW = shOut;
      2'b10:   busW = mulRes;
      default: busW = bus.dIn;
    endcase
  end

  always_ff @(posedge clk) begin
    if (bus.wbEn && (bus.wbIdx != PC_IDX)) begin
      regFile[bus.wbIdx] <= busW;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iAddrR           <= '0;
      dAddrR           <= '0;
      dOutR            <= '0;
      {nR, zR, cR, vR} <= 4'b0000;
    end else begin
      if (!mulBusyW) begin
        iAddrR <= bus.iAregCtl ? aluOut : iAddrR + WIDTH'(1);
      end
      if (bus.dAregCtl) begin
        dAddrR <= aluOut;
      end
      if (bus.dOutCtl) begin
        dOutR <= busB;
      end
      if (bus.srWbEn) begin
        if (bus.cmpFlag) begin
          {nR, zR, cR, vR} <= {aluN, aluZ, aluC, aluV};
        end else begin
          {nR, zR, cR, vR} <= busW[WIDTH-1:WIDTH-4];
        end
      end
    end
  end

`ifdef SC_DP_MUL_EN
  typedef enum logic {MUL_IDLE, MUL_RUN} mulState_t;

  mulState_t        mulState;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [SW:0]      count;
  logic             doneR;

  // Shift-add: one multiplier bit per RUN cycle; acc holds the product until the next start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mulState <= MUL_IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      doneR    <= 1'b0;
    end else begin
      doneR <= 1'b0;
      case (mulState)
        MUL_IDLE: begin
          if (bus.mulStart) begin
            mcand    <= busA;
            mplier   <= busB;
            acc      <= '0;
            count    <= (SW + 1)'(WIDTH);
            mulState <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - (SW + 1)'(1);
          if (count == (SW + 1)'(1)) begin
            mulState <= MUL_IDLE;
            doneR    <= 1'b1;
          end
        end
      endcase
    end
  end

  assign mulBusyW = (mulState == MUL_RUN);
  assign mulDoneW = doneR;
  assign mulRes   = acc;
`else
  logic unusedMulStart;

  assign unusedMulStart = bus.mulStart;
  assign mulBusyW       = 1'b0;
  assign mulDoneW       = 1'b0;
  assign mulRes         = '0;
`endif

  assign bus.mulBusy = mulBusyW;
  assign bus.mulDone = mulDoneW;
  assign bus.iAddr   = iAddrR;
  assign bus.dAddr   = dAddrR;
  assign bus.dOut    = dOutR;
  assign bus.nFlag   = nR;
  assign bus.zFlag   = zR;
  assign bus.cFlag   = cR;
  assign bus.vFlag   = vR;
endmodule

// File: doc/sc_datapath2.md
# sc_datapath2

Parametrised second-generation SimpleCore datapath: register file, ALU, barrel shifter, iterative multiplier, NZCV status register, and instruction/data address and data-out registers. Internal tristate buses are replaced by explicit muxes. Adds a multi-cycle multiplier with a start/busy/done handshake that stalls the instruction address. Sits between the SimpleCore controller and the instruction/data memory ports.

## Interface
Parameters:
- WIDTH, 16, datapath width (≥8, power of two)
- NREG, 16, register count (power of two, ≥4); register NREG-1 is the PC alias
- RW, $clog2(NREG), register index width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- imm  in  WIDTH  immediate operand
- opAIdx, opBIdx  in  RW  read indices A/B
- immSel  in  1  1: busB = imm; 0: register B
- wbIdx  in  RW  writeback index
- wbEn  in  1  register write enable
- resSel  in  2  writeback source: 00 ALU, 01 shifter, 10 multiplier, 11 dIn
- aluCtl  in  3  ALU operation
- shiftCtl  in  3  shifter operation
- srWbEn  in  1  status register update enable
- cmpFlag  in  1  1: flags from ALU; 0: flags from busW[WIDTH-1:WIDTH-4]
- mulStart  in  1  multiplier start request
- iAregCtl  in  1  0: iAddr+1; 1: aluOut
- dAregCtl  in  1  load dAddr from aluOut
- dOutCtl  in  1  load dOut from busB
- dIn  in  WIDTH  memory read data
- mulBusy  out  1  multiplier running
- mulDone  out  1  one-cycle result-ready pulse
- zFlag, nFlag, cFlag, vFlag  out  1  status flags
- iAddr, dAddr, dOut  out  WIDTH  instruction address, data address, write data

## Operation
- Register file: NREG×WIDTH, combinational read, write on clk when wbEn. Reads of index NREG-1 return iAddr; writes to it are dropped. No write-to-read bypass; a same-cycle read returns the old value. Registers are not reset.
- ALU on busA/busB: 000 ADD, 001 SUB (A−B), 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 PASS B, 111 PASS A.
- ALU flags: Z = result==0; N = MSB; C = carry-out for ADD, borrow (A<B unsigned) for SUB, else 0; V = signed overflow for ADD/SUB, else 0.
- Shifter on busA, amount busB[log2(WIDTH)-1:0]: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others PASS A. Amount 0 passes A through.
- Status register: when srWbEn, loads ALU flags if cmpFlag=1, else {N,Z,C,V} = busW[WIDTH-1:WIDTH-4]. Reading the status register is not supported.
- Multiplier FSM, IDLE→RUN→IDLE:
  - In IDLE, mulStart captures busA/busB, clears the accumulator, sets count=WIDTH and enters RUN.
  - Each RUN cycle performs one shift-add step and decrements count.
  - On the step where count reaches 0, the FSM returns to IDLE and pulses mulDone.
  - Result is the low WIDTH bits of A×B (unsigned), held until the next start.
  - mulStart during RUN is ignored.
- iAddr: updates every cycle per iAregCtl (+1 wraps from all-ones to 0); holds while mulBusy=1.

## Timing
- Reset (async assert, sync release): iAddr=0, dAddr=0, dOut=0, all flags 0, FSM IDLE, mulBusy=0, mulDone=0, multiplier result 0.
- Reset during RUN aborts the operation; no mulDone pulse.
- Multiply, start accepted at edge k:
  - mulBusy=1 after edges k … k+WIDTH-1.
  - mulBusy=0 and mulDone=1 after edge k+WIDTH, for exactly one cycle.
  - Result is valid on resSel=10 from that cycle on.
- iAddr does not advance on edges k+1 … k+WIDTH. It advances normally at edge k, because mulBusy was still 0 then.
- dAddr, dOut, and register writes are not stalled; the controller is responsible for sequencing them.
- All outputs are registered except mulBusy and mulDone, which are FSM state decodes.

## Configuration
- SC_DP_MUL_EN defined: iterative multiplier and handshake present as above.
- SC_DP_MUL_EN undefined: multiplier logic removed. mulStart is ignored, mulBusy=0 and mulDone=0 always, resSel=10 writes 0, and iAddr never stalls.

## Test plan
- Reset release → iAddr=0x0000 and flags 0. Five free-running cycles with iAregCtl=0 → iAddr=0x0005.
- R1=0x7FFF, R2=0x0001, ADD with srWbEn=1, cmpFlag=1 → result 0x8000, N=1, V=1, Z=0, C=0. SUB 0x0001−0x0002 → 0xFFFF, C=1, N=1.
- SRA of 0x8004 by 2 → 0xE001. ROR of 0x0001 by 1 → 0x8000. Shift amount 0 → value unchanged.
- mulStart with A=0x0123, B=0x0010 → mulBusy high 16 cycles, mulDone pulse on cycle 16, writeback 0x1230, iAddr frozen during busy. A second mulStart while busy is ignored.
- Assert reset at cycle 8 of a multiply → mulBusy=0, no mulDone, iAddr=0.
- Write R3 and read R3 in the same cycle → old value returned; new value on the next cycle. Write to R15 is ignored, and reading R15 returns iAddr.
